// File: rtl/vga_box_renderer_pkg.sv
// rtl/vga_box_renderer_pkg.sv - shared screen geometry, register map and config record for the box renderer
package vga_box_renderer_pkg;

    localparam int H_PIXELS  = 640;
    localparam int V_PIXELS  = 480;
    localparam int H_TOTAL   = 800;
    localparam int RST_SIZE  = 32;
    localparam int CHECK_BIT = 5;

    localparam logic [2:0] ADDR_CTRL  = 3'd0;
    localparam logic [2:0] ADDR_SIZE  = 3'd1;
    localparam logic [2:0] ADDR_SPEED = 3'd2;
    localparam logic [2:0] ADDR_RED   = 3'd3;
    localparam logic [2:0] ADDR_GREEN = 3'd4;
    localparam logic [2:0] ADDR_BLUE  = 3'd5;

    typedef struct packed {
        logic       run;
        logic       chk;
        logic [7:0] size;
        logic [3:0] dx;
        logic [3:0] dy;
        logic [9:0] red;
        logic [9:0] green;
        logic [9:0] blue;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        run:   1'b0,
        chk:   1'b1,
        size:  8'(RST_SIZE),
        dx:    4'd1,
        dy:    4'd1,
        red:   10'h3FF,
        green: 10'h3FF,
        blue:  10'h3FF
    };

    // A zero size would make the box vanish and the clamp limit degenerate, so it is stored as 1.
    function automatic cfg_t cfg_write(input cfg_t c, input logic [2:0] addr, input logic [9:0] data);
        cfg_t r;
        r = c;
        case (addr)
            ADDR_CTRL:  begin
                r.run = data[0];
                r.chk = data[1];
            end
            ADDR_SIZE:  r.size = (data[7:0] == 8'd0) ? 8'd1 : data[7:0];
            ADDR_SPEED: begin
                r.dx = data[3:0];
                r.dy = data[7:4];
            end
            ADDR_RED:   r.red   = data;
            ADDR_GREEN: r.green = data;
            ADDR_BLUE:  r.blue  = data;
            default:    ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// rtl/vga_bounce_axis.sv - one axis of box position with clamp and edge bounce, stepped once per frame tick
module vga_bounce_axis #(
    parameter int LIMIT = 640
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic [7:0] i_size,
    input  logic [3:0] i_delta,
    output logic [9:0] o_pos
);

    logic [9:0]  r_pos;
    logic        r_dir;
    logic [10:0] w_lim;
    logic [10:0] w_clamp;
    logic [10:0] w_sum;
    logic [10:0] w_delta;
    logic [10:0] w_nxt;
    logic        w_nxt_dir;

    // r_dir = 0 moves towards increasing coordinates; 11-bit math keeps x+dx from wrapping.
    assign w_delta = {7'd0, i_delta};
    assign w_lim   = 11'(LIMIT) - {3'd0, i_size};
    assign w_clamp = ({1'b0, r_pos} > w_lim) ? w_lim : {1'b0, r_pos};
    assign w_sum   = w_clamp + w_delta;

    always_comb begin
        w_nxt     = w_clamp;
        w_nxt_dir = r_dir;
        if (i_run && (i_delta != 4'd0)) begin
            if (!r_dir) begin
                if (w_sum >= w_lim) begin
                    w_nxt     = w_lim;
                    w_nxt_dir = 1'b1;
                end else begin
                    w_nxt = w_sum;
                end
            end else begin
                if (w_clamp <= w_delta) begin
                    w_nxt     = 11'd0;
                    w_nxt_dir = 1'b0;
                end else begin
                    w_nxt = w_clamp - w_delta;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pos <= 10'd0;
            r_dir <= 1'b0;
        end else if (i_tick) begin
            r_pos <= w_nxt[9:0];
            r_dir <= w_nxt_dir;
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/vga_box_renderer.sv
// rtl/vga_box_renderer.sv - bouncing box over checkerboard, colour source one pixel ahead of VGA_Sync
module vga_box_renderer
    import vga_box_renderer_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iPX,
    input  logic [9:0] iPY,
    input  logic       iWE,
    input  logic [2:0] iADDR,
    input  logic [9:0] iWDATA,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oFrameTick,
    output logic [9:0] oBoxX,
    output logic [9:0] oBoxY
);

    cfg_t        r_shadow;
    cfg_t        w_cfg_nxt;
    logic        r_chk;
    logic [7:0]  r_size;
    logic [9:0]  r_box_red;
    logic [9:0]  r_box_green;
    logic [9:0]  r_box_blue;
    logic [9:0]  r_red;
    logic [9:0]  r_green;
    logic [9:0]  r_blue;
    logic        r_tick;
    logic        w_tick;
    logic [9:0]  w_nx;
    logic [9:0]  w_box_x;
    logic [9:0]  w_box_y;
    logic        w_in_active;
    logic        w_in_box;
    logic [29:0] w_pix;

    // The tick-cycle write is merged before the copy so it takes effect at that same tick.
    assign w_cfg_nxt = iWE ? cfg_write(r_shadow, iADDR, iWDATA) : r_shadow;
    assign w_tick    = (iPX == 10'd0) && (iPY == 10'(V_PIXELS));

    vga_bounce_axis #(.LIMIT(H_PIXELS)) u_axis_x (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_tick  (w_tick),
        .i_run   (w_cfg_nxt.run),
        .i_size  (w_cfg_nxt.size),
        .i_delta (w_cfg_nxt.dx),
        .o_pos   (w_box_x)
    );

    vga_bounce_axis #(.LIMIT(V_PIXELS)) u_axis_y (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_tick  (w_tick),
        .i_run   (w_cfg_nxt.run),
        .i_size  (w_cfg_nxt.size),
        .i_delta (w_cfg_nxt.dy),
        .o_pos   (w_box_y)
    );

    // Look one pixel ahead so the registered colour lines up with the coordinate VGA_Sync shows.
    assign w_nx        = (iPX == 10'(H_TOTAL - 1)) ? 10'd0 : iPX + 10'd1;
    assign w_in_active = (w_nx < 10'(H_PIXELS)) && (iPY < 10'(V_PIXELS));
    assign w_in_box    = ({1'b0, w_nx} >= {1'b0, w_box_x}) &&
                         ({1'b0, w_nx} <  ({1'b0, w_box_x} + {3'd0, r_size})) &&
                         ({1'b0, iPY}  >= {1'b0, w_box_y}) &&
                         ({1'b0, iPY}  <  ({1'b0, w_box_y} + {3'd0, r_size}));

    always_comb begin
        w_pix = 30'd0;
        if (w_in_active) begin
            if (w_in_box) begin
                w_pix = {r_box_red, r_box_green, r_box_blue};
            end else if (r_chk && (w_nx[CHECK_BIT] ^ iPY[CHECK_BIT])) begin
                w_pix = {3{10'h200}};
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_shadow    <= CFG_RESET;
            r_chk       <= CFG_RESET.chk;
            r_size      <= CFG_RESET.size;
            r_box_red   <= CFG_RESET.red;
            r_box_green <= CFG_RESET.green;
            r_box_blue  <= CFG_RESET.blue;
            r_red       <= 10'd0;
            r_green     <= 10'd0;
            r_blue      <= 10'd0;
            r_tick      <= 1'b0;
        end else begin
            r_shadow <= w_cfg_nxt;
            if (w_tick) begin
                r_chk       <= w_cfg_nxt.chk;
                r_size      <= w_cfg_nxt.size;
                r_box_red   <= w_cfg_nxt.red;
                r_box_green <= w_cfg_nxt.green;
                r_box_blue  <= w_cfg_nxt.blue;
            end
            r_red   <= w_pix[29:20];
            r_green <= w_pix[19:10];
            r_blue  <= w_pix[9:0];
            r_tick  <= w_tick;
        end
    end

    assign oRed       = r_red;
    assign oGreen     = r_green;
    assign oBlue      = r_blue;
    assign oFrameTick = r_tick;
    assign oBoxX      = w_box_x;
    assign oBoxY      = w_box_y;

endmodule

// File: tb/tb_vga_box_renderer.sv
// tb/tb_vga_box_renderer.sv - table, directed and randomized checks of vga_box_renderer against a behavioural model
module tb_vga_box_renderer;

    logic       clk = 1'b0;
    logic       iRST = 1'b1;
    logic [9:0] iPX = '0;
    logic [9:0] iPY = '0;
    logic       iWE = 1'b0;
    logic [2:0] iADDR = '0;
    logic [9:0] iWDATA = '0;
    logic [9:0] oRed, oGreen, oBlue, oBoxX, oBoxY;
    logic       oFrameTick;

    always #5 clk = ~clk;

    vga_box_renderer dut (
        .iCLK(clk), .iRST(iRST), .iPX(iPX), .iPY(iPY), .iWE(iWE), .iADDR(iADDR), .iWDATA(iWDATA),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oFrameTick(oFrameTick), .oBoxX(oBoxX), .oBoxY(oBoxY)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: shadow and active settings, box position, heading, expected outputs.
    int s_run, s_chk, s_size, s_dx, s_dy, s_r, s_g, s_b;
    int a_chk, a_size, a_r, a_g, a_b;
    int m_x, m_y;
    bit m_fwd_x, m_fwd_y;
    int e_r, e_g, e_b, e_tick;

    typedef struct {
        int px;
        int py;
        int col;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        s_run = 0; s_chk = 1; s_size = 32; s_dx = 1; s_dy = 1;
        s_r = 'h3FF; s_g = 'h3FF; s_b = 'h3FF;
        a_chk = 1; a_size = 32; a_r = 'h3FF; a_g = 'h3FF; a_b = 'h3FF;
        m_x = 0; m_y = 0; m_fwd_x = 1; m_fwd_y = 1;
        e_r = 0; e_g = 0; e_b = 0; e_tick = 0;
    endtask

    task automatic move(inout int pos, inout bit fwd, input int span, input int size, input int d, input int run);
        int lim;
        lim = span - size;
        if (pos > lim) pos = lim;
        if (run != 0 && d > 0) begin
            if (fwd) begin
                if (pos + d >= lim) begin pos = lim; fwd = 0; end
                else pos = pos + d;
            end else begin
                if (pos <= d) begin pos = 0; fwd = 1; end
                else pos = pos - d;
            end
        end
    endtask

    task automatic model_cycle(input int px, input int py, input bit we, input int addr, input int d);
        int nx;
        nx = (px == 799) ? 0 : px + 1;
        e_r = 0; e_g = 0; e_b = 0;
        if (nx < 640 && py < 480) begin
            if (nx >= m_x && nx < m_x + a_size && py >= m_y && py < m_y + a_size) begin
                e_r = a_r; e_g = a_g; e_b = a_b;
            end else if (a_chk != 0 && ((nx / 32) % 2) != ((py / 32) % 2)) begin
                e_r = 'h200; e_g = 'h200; e_b = 'h200;
            end
        end
        e_tick = (px == 0 && py == 480) ? 1 : 0;
        if (we) begin
            case (addr)
                0: begin s_run = d % 2; s_chk = (d / 2) % 2; end
                1: begin s_size = d % 256; if (s_size == 0) s_size = 1; end
                2: begin s_dx = d % 16; s_dy = (d / 16) % 16; end
                3: s_r = d;
                4: s_g = d;
                5: s_b = d;
                default: ;
            endcase
        end
        if (e_tick != 0) begin
            a_chk = s_chk; a_size = s_size; a_r = s_r; a_g = s_g; a_b = s_b;
            move(m_x, m_fwd_x, 640, s_size, s_dx, s_run);
            move(m_y, m_fwd_y, 480, s_size, s_dy, s_run);
        end
    endtask

    task automatic step(input bit rst, input int px, input int py, input bit we, input int addr, input int d);
        iRST = rst; iPX = 10'(px); iPY = 10'(py); iWE = we; iADDR = 3'(addr); iWDATA = 10'(d);
        @(posedge clk);
        if (rst) model_reset();
        else model_cycle(px, py, we, addr, d);
        #1;
        check("red", int'(oRed), e_r);
        check("green", int'(oGreen), e_g);
        check("blue", int'(oBlue), e_b);
        check("tick", int'(oFrameTick), e_tick);
        check("box_x", int'(oBoxX), m_x);
        check("box_y", int'(oBoxY), m_y);
    endtask

    task automatic wr(input int addr, input int d);
        step(0, 300, 100, 1, addr, d);
    endtask

    task automatic tick();
        step(0, 0, 480, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{100, 100, 'h000};
        tbl[1]  = '{10,  10,  'h3FF};
        tbl[2]  = '{40,  10,  'h200};
        tbl[3]  = '{700, 10,  'h000};
        tbl[4]  = '{799, 10,  'h3FF};
        tbl[5]  = '{30,  31,  'h3FF};
        tbl[6]  = '{31,  31,  'h200};
        tbl[7]  = '{100, 479, 'h200};
        tbl[8]  = '{100, 480, 'h000};
        tbl[9]  = '{638, 0,   'h200};
        tbl[10] = '{639, 0,   'h000};
        tbl[11] = '{10,  40,  'h200};

        model_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

        // T1: reset rendering at fixed coordinates.
        for (int i = 0; i < 12; i++) begin
            step(0, tbl[i].px, tbl[i].py, 0, 0, 0);
            check("t1_red", int'(oRed), tbl[i].col);
            check("t1_green", int'(oGreen), tbl[i].col);
            check("t1_blue", int'(oBlue), tbl[i].col);
        end

        // T2: approach right edge and bounce.
        wr(2, 15);
        wr(0, 3);
        for (int i = 0; i < 40; i++) tick();
        check("t2_x600", int'(oBoxX), 600);
        wr(2, 4);
        tick(); check("t2_x604", int'(oBoxX), 604);
        tick(); check("t2_x608", int'(oBoxX), 608);
        tick(); check("t2_x604_back", int'(oBoxX), 604);

        // T3: left bounce at x=3 and frozen motion with dx=0.
        wr(2, 15);
        for (int i = 0; i < 40; i++) tick();
        check("t3_x4", int'(oBoxX), 4);
        wr(2, 1); tick(); check("t3_x3", int'(oBoxX), 3);
        wr(2, 4); tick(); check("t3_x0", int'(oBoxX), 0);
        wr(2, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); check("t3_frozen", int'(oBoxX), 0);
        end
        wr(2, 1); tick(); check("t3_dir_right", int'(oBoxX), 1);

        // T4: colour writes take effect only at a tick, including one in the tick cycle.
        wr(3, 'h155);
        step(0, 5, 5, 0, 0, 0); check("t4_red_held", int'(oRed), 'h3FF);
        tick();
        step(0, 5, 5, 0, 0, 0); check("t4_red_new", int'(oRed), 'h155);
        step(0, 0, 480, 1, 4, 'h0AA);
        step(0, 5, 5, 0, 0, 0); check("t4_green_tickwr", int'(oGreen), 'h0AA);

        // T5: clamp on size growth, size 0 stored as 1.
        wr(1, 16);
        wr(2, 15);
        for (int i = 0; i < 41; i++) tick();
        check("t5_x618", int'(oBoxX), 618);
        wr(2, 2); tick(); check("t5_x620", int'(oBoxX), 620);
        wr(0, 2);
        wr(1, 64); tick(); check("t5_clamp576", int'(oBoxX), 576);
        wr(1, 0); tick();
        step(0, 575, 0, 0, 0, 0); check("t5_size1_in", int'(oRed), 'h155);
        step(0, 576, 0, 0, 0, 0); check("t5_size1_out", int'(oRed), 'h000);
        step(0, 574, 0, 0, 0, 0); check("t5_grey", int'(oRed), 'h200);

        // T6: reset mid-line discards a simultaneous write.
        step(0, 300, 100, 0, 0, 0);
        step(1, 300, 100, 1, 3, 0);
        check("t6_red0", int'(oRed), 0);
        check("t6_x0", int'(oBoxX), 0);
        step(0, 10, 10, 0, 0, 0); check("t6_box", int'(oRed), 'h3FF);
        tick();
        step(0, 10, 10, 0, 0, 0); check("t6_no_pending", int'(oRed), 'h3FF);
        check("t6_still_x0", int'(oBoxX), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r, px, py, we, addr, d;
            r = int'($urandom_range(0, 199));
            we = ($urandom_range(0, 99) < 15) ? 1 : 0;
            addr = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 1023));
            if (addr == 0 && $urandom_range(0, 3) != 0) d = d | 1;
            if (r < 2) begin
                step(1, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'(we), addr, d);
            end else if (r < 40) begin
                step(0, 0, 480, 1'(we), addr, d);
            end else begin
                if (r < 120) begin
                    px = m_x + int'($urandom_range(0, 36)) - 2;
                    py = m_y + int'($urandom_range(0, 36)) - 2;
                    if (px < 0) px = 0;
                    if (py < 0) py = 0;
                    if (px > 799) px = 799;
                    if (py > 524) py = 524;
                end else begin
                    px = int'($urandom_range(0, 799));
                    py = int'($urandom_range(0, 524));
                end
                step(0, px, py, 1'(we), addr, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
